// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: instruction-word field positions, idle instruction and sequencer states
package conv_seq_pkg;
   localparam int IW = 47;
   localparam int AW = 11;
   localparam int B_CEN_X = 46;
   localparam int B_WEN_X = 45;
   localparam int B_A_X = 34;
   localparam int B_ACC = 33;
   localparam int B_CEN_P = 32;
   localparam int B_WEN_P = 31;
   localparam int B_A_P = 20;
   localparam int B_CEN_W = 19;
   localparam int B_WEN_W = 18;
   localparam int B_A_W = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD = 3;
   localparam int B_L0_WR = 2;
   localparam int B_EXEC = 1;
   localparam int B_LOAD = 0;
   localparam logic [IW-1:0] ONE = 1;
   localparam logic [IW-1:0] IDLE_INST = (ONE << B_CEN_X) | (ONE << B_WEN_X) | (ONE << B_CEN_P) |
                                         (ONE << B_WEN_P) | (ONE << B_CEN_W) | (ONE << B_WEN_W);
   typedef enum logic [3:0] {
      IDLE, WFETCH, PLOAD, GAP, XFETCH, EXEC, DRAIN, ACC_CLR, ACC_RD, ACC_OUT, FIN
   } state_t;
endpackage

// File: rtl/psum_addr_gen.sv
// psum_addr_gen: psum read address j*len_nij + (oy+kiy)*ni_dim + (ox+kjx), kept as two
// incrementally stepped bases (output pixel, kernel position) so no multiply/divide is needed.
module psum_addr_gen #(
   parameter int ki_dim = 3, ni_dim = 6, len_nij = 36, oni_dim = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr_o,
   input  logic        i_step_o,
   input  logic        i_clr_j,
   input  logic        i_step_j,
   output logic [10:0] o_addr
);
   localparam int OXW = $clog2(oni_dim + 1);
   localparam int KXW = $clog2(ki_dim + 1);
   localparam logic [OXW-1:0] OX_LAST = OXW'(oni_dim - 1);
   localparam logic [KXW-1:0] KX_LAST = KXW'(ki_dim - 1);
   logic [OXW-1:0] r_ox;
   logic [KXW-1:0] r_kjx;
   logic [10:0] r_obase, r_kbase;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ox <= '0;
         r_obase <= '0;
         r_kjx <= '0;
         r_kbase <= '0;
      end else begin
         if (i_clr_o) begin
            r_ox <= '0;
            r_obase <= '0;
         end else if (i_step_o) begin
            r_ox <= r_ox == OX_LAST ? '0 : r_ox + 1'b1;
            r_obase <= r_obase + (r_ox == OX_LAST ? 11'(ni_dim - oni_dim + 1) : 11'd1);
         end
         if (i_clr_j) begin
            r_kjx <= '0;
            r_kbase <= '0;
         end else if (i_step_j) begin
            r_kjx <= r_kjx == KX_LAST ? '0 : r_kjx + 1'b1;
            r_kbase <= r_kbase + (r_kjx == KX_LAST ? 11'(len_nij + ni_dim - ki_dim + 1) : 11'(len_nij + 1));
         end
      end
   end
   assign o_addr = r_obase + r_kbase;
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: drives core.inst through a full 3x3 convolution tile: per kij fetch/load/
// execute/drain, then one accumulation pass per output pixel.
module conv_seq_ctrl
   import conv_seq_pkg::*;
#(
   parameter int row = 8, col = 8, len_kij = 9, ki_dim = 3, len_nij = 36, ni_dim = 6,
   parameter int len_onij = 16, oni_dim = 4, gap_cyc = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ofifo_valid,
   output logic [IW-1:0] inst,
   output logic          busy,
   output logic          done,
   output logic          out_strobe,
   output logic [4:0]    out_idx,
   output logic [3:0]    kij_idx
);
   localparam int CW = $clog2(len_nij + row + col + gap_cyc + len_kij + 2);
   localparam logic [CW-1:0] L_COL = CW'(col);
   localparam logic [CW-1:0] L_PL = CW'(row + col - 2);
   localparam logic [CW-1:0] L_GAP = CW'(gap_cyc - 1);
   localparam logic [CW-1:0] L_XF = CW'(len_nij);
   localparam logic [CW-1:0] L_EX = CW'(len_nij + row + col - 2);
   localparam logic [CW-1:0] L_DR = CW'(len_nij - 1);
   localparam logic [CW-1:0] L_AR = CW'(len_kij);
   localparam logic [3:0] L_KIJ = 4'(len_kij - 1);
   localparam logic [4:0] L_O = 5'(len_onij - 1);
   if (len_kij * len_nij > 2048 || len_kij * col > 2048 || len_nij > 2048 ||
       len_kij > 16 || len_onij > 32 || gap_cyc < 1) begin : g_bad_params
      $error("conv_seq_ctrl: parameter set exceeds address or index widths");
   end
   state_t r_state, w_next;
   logic [CW-1:0] r_c;
   logic [3:0] r_kij;
   logic [4:0] r_o, r_out_idx;
   logic [IW-1:0] r_inst, w_inst;
   logic r_busy, r_done, r_out_strobe;
   logic [AW-1:0] w_a_wmem, w_a_drain, w_a_acc;
   psum_addr_gen #(
      .ki_dim(ki_dim), .ni_dim(ni_dim), .len_nij(len_nij), .oni_dim(oni_dim)
   ) u_addr (
      .clk(clk),
      .reset(reset),
      .i_clr_o(r_state == IDLE),
      .i_step_o(r_state == ACC_OUT),
      .i_clr_j(r_state == ACC_CLR),
      .i_step_j(r_state == ACC_RD),
      .o_addr(w_a_acc)
   );
   assign w_a_wmem = AW'(r_kij) * AW'(col) + AW'(r_c);
   assign w_a_drain = AW'(r_kij) * AW'(len_nij) + AW'(r_c);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = start ? WFETCH : IDLE;
         WFETCH:  w_next = r_c == L_COL ? PLOAD : WFETCH;
         PLOAD:   w_next = r_c == L_PL ? GAP : PLOAD;
         GAP:     w_next = r_c == L_GAP ? XFETCH : GAP;
         XFETCH:  w_next = r_c == L_XF ? EXEC : XFETCH;
         EXEC:    w_next = r_c == L_EX ? DRAIN : EXEC;
         DRAIN:   w_next = (ofifo_valid && r_c == L_DR) ? (r_kij == L_KIJ ? ACC_CLR : WFETCH) : DRAIN;
         ACC_CLR: w_next = ACC_RD;
         ACC_RD:  w_next = r_c == L_AR ? ACC_OUT : ACC_RD;
         ACC_OUT: w_next = r_o == L_O ? FIN : ACC_CLR;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // r_c is the per-phase counter (c, d or j); it only advances in DRAIN on an actual pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_c <= '0;
         r_kij <= '0;
         r_o <= '0;
         r_inst <= IDLE_INST;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_out_strobe <= 1'b0;
         r_out_idx <= '0;
      end else begin
         r_c <= (w_next != r_state) ? '0 :
                (r_state == IDLE || (r_state == DRAIN && !ofifo_valid)) ? r_c : r_c + 1'b1;
         r_kij <= r_state == IDLE ? '0 : (r_state == DRAIN && w_next == WFETCH) ? r_kij + 1'b1 : r_kij;
         r_o <= r_state == IDLE ? '0 : (r_state == ACC_OUT && w_next == ACC_CLR) ? r_o + 1'b1 : r_o;
         r_inst <= w_inst;
         r_busy <= w_next != IDLE;
         r_done <= r_state == FIN;
         r_out_strobe <= r_state == ACC_OUT;
         r_out_idx <= r_state == ACC_OUT ? r_o : r_out_idx;
      end
   end
   // consumer write strobes sit one counter step behind the SRAM read enable
   always_comb begin
      w_inst = IDLE_INST;
      unique case (r_state)
         WFETCH: begin
            w_inst[B_CEN_W] = r_c >= L_COL;
            w_inst[B_A_W +: AW] = w_a_wmem;
            w_inst[B_IFIFO_WR] = r_c != '0;
         end
         PLOAD: begin
            w_inst[B_IFIFO_RD] = 1'b1;
            w_inst[B_LOAD] = 1'b1;
         end
         XFETCH: begin
            w_inst[B_CEN_X] = r_c >= L_XF;
            w_inst[B_A_X +: AW] = AW'(r_c);
            w_inst[B_L0_WR] = r_c != '0;
         end
         EXEC: begin
            w_inst[B_L0_RD] = 1'b1;
            w_inst[B_EXEC] = 1'b1;
         end
         DRAIN: begin
            w_inst[B_OFIFO_RD] = ofifo_valid;
            w_inst[B_CEN_P] = !ofifo_valid;
            w_inst[B_WEN_P] = !ofifo_valid;
            w_inst[B_A_P +: AW] = w_a_drain;
         end
         ACC_RD: begin
            w_inst[B_CEN_P] = r_c >= L_AR;
            w_inst[B_A_P +: AW] = w_a_acc;
            w_inst[B_ACC] = r_c != '0;
         end
         default: ;
      endcase
   end
   assign inst = r_inst;
   assign busy = r_busy;
   assign done = r_done;
   assign out_strobe = r_out_strobe;
   assign out_idx = r_out_idx;
   assign kij_idx = r_kij;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench; expected instruction events are queued by the stimulus
// and popped by a negedge monitor that decodes inst, out_strobe and done.
module tb_conv_seq_ctrl;
   localparam int K_WRD = 0, K_IFRUN = 1, K_LOAD = 2, K_L0 = 3, K_EXE = 4;
   localparam int K_PWR = 5, K_PRD = 6, K_ACC = 7, K_OUT = 8, K_DONE = 9;
   localparam logic [46:0] IDLE_I = 47'h6001_800C_0000;
   typedef struct {int kind; int val;} ev_t;
   logic clk = 0, reset = 1, start = 0, ofifo_valid = 1;
   logic [46:0] inst;
   logic busy, done, out_strobe;
   logic [4:0] out_idx;
   logic [3:0] kij_idx;
   ev_t exp_q[$];
   int n_tests = 0, n_fail = 0;
   bit stall_en = 0;
   int stall_ph = 0;
   bit prev_valid = 0;
   int run_cnt[5] = '{0, 0, 0, 0, 0};
   int run_bit[5] = '{5, 0, 2, 1, 33};
   int run_kind[5] = '{K_IFRUN, K_LOAD, K_L0, K_EXE, K_ACC};
   string kn[10] = '{"wmem_rd", "ififo_wr_run", "load_run", "l0_wr_run", "exec_run",
                     "pmem_wr", "pmem_rd", "acc_run", "out_idx", "done_busy"};

   conv_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid), .inst(inst),
      .busy(busy), .done(done), .out_strobe(out_strobe), .out_idx(out_idx), .kij_idx(kij_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input int k, input int v);
      exp_q.push_back('{k, v});
   endtask

   task automatic push_kij_front(input int k);
      for (int c = 0; c < 8; c++) push(K_WRD, k * 8 + c);
      push(K_IFRUN, 8);
      push(K_LOAD, 15);
      push(K_L0, 36);
   endtask

   task automatic push_run();
      for (int k = 0; k < 9; k++) begin
         push_kij_front(k);
         push(K_EXE, 51);
         for (int d = 0; d < 36; d++) push(K_PWR, k * 36 + d);
      end
      for (int o = 0; o < 16; o++) begin
         for (int j = 0; j < 9; j++) push(K_PRD, j * 36 + (o / 4 + j / 3) * 6 + o % 4 + j % 3);
         push(K_ACC, 9);
         push(K_OUT, o);
      end
      push(K_DONE, 0);
   endtask

   task automatic emit(input int k, input int v);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got %s=%0d, required no event", kn[k], v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            n_fail++;
            $display("FAIL %s: got %s=%0d, required %s=%0d", kn[e.kind], kn[k], v, kn[e.kind], e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 5; i++) run_cnt[i] = 0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (inst[run_bit[i]]) run_cnt[i]++;
            else if (run_cnt[i] > 0) begin
               emit(run_kind[i], run_cnt[i]);
               run_cnt[i] = 0;
            end
         end
         if (!inst[19]) emit(K_WRD, int'(inst[17:7]));
         if (!inst[32] && !inst[31]) begin
            emit(K_PWR, int'(inst[30:20]));
            check("pwr_needs_valid", 64'(prev_valid), 64'd1);
            check("pwr_ofifo_rd", 64'(inst[6]), 64'd1);
         end
         if (!inst[32] && inst[31]) emit(K_PRD, int'(inst[30:20]));
         if (out_strobe) emit(K_OUT, int'(out_idx));
         if (done) emit(K_DONE, int'(busy));
      end
      prev_valid = ofifo_valid;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (stall_en && kij_idx == 4'd2) begin
         ofifo_valid = (stall_ph == 0);
         stall_ph = (stall_ph + 1) % 3;
      end else ofifo_valid = 1;
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk);
         #1;
         if (done) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no done pulse, required done within 6000 cycles", name);
   endtask

   initial begin
      bit found;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inst", 64'(inst), 64'(IDLE_I));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out_strobe", 64'(out_strobe), 64'd0);
      check("rst_out_idx", 64'(out_idx), 64'd0);
      check("rst_kij_idx", 64'(kij_idx), 64'd0);
      reset = 0;
      push_run();
      stall_en = 1;
      pulse_start();
      check("busy_after_start", 64'(busy), 64'd1);
      found = 0;
      for (int i = 0; i < 4000 && !found; i++) begin
         @(posedge clk);
         #1;
         found = (kij_idx == 4'd4) && inst[6];
      end
      check("reach_drain_kij4", 64'(found), 64'd1);
      pulse_start();
      wait_done("run1_done");
      stall_en = 0;
      repeat (20) @(posedge clk);
      #1;
      check("run1_queue_empty", 64'(exp_q.size()), 64'd0);
      check("run1_busy_idle", 64'(busy), 64'd0);
      push_kij_front(0);
      pulse_start();
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk);
         #1;
         found = inst[1];
      end
      check("reach_exec", 64'(found), 64'd1);
      repeat (20) @(posedge clk);
      #3 reset = 1;
      #1;
      check("midrun_queue_empty", 64'(exp_q.size()), 64'd0);
      check("midrun_rst_inst", 64'(inst), 64'(IDLE_I));
      check("midrun_rst_busy", 64'(busy), 64'd0);
      check("midrun_rst_kij", 64'(kij_idx), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      push_run();
      pulse_start();
      wait_done("run3_done");
      repeat (20) @(posedge clk);
      #1;
      check("run3_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500000 ns");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- On-chip sequencer that generates the 47-bit instruction word for `core` to run a full 3x3 convolution tile without host cycle-by-cycle control.
- Per kernel index kij it steps through five phases: weight fetch to IFIFO, PE weight load, activation fetch to L0, execute, OFIFO drain to psum memory.
- It then runs the accumulation pass, reading psum addresses computed on the fly.
- It sits between the host/testbench start interface and `core.inst`.

Parameters:
- row, 8, PE array rows (input channels)
- col, 8, PE array columns (output channels)
- len_kij, 9, kernel positions (3x3)
- ki_dim, 3, kernel side
- len_nij, 36, input pixels (6x6)
- ni_dim, 6, input side
- len_onij, 16, output pixels (4x4)
- oni_dim, 4, output side
- gap_cyc, 10, idle cycles between PE load and activation fetch

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a full tile run; sampled only in IDLE
- ofifo_valid  in  1  from core; OFIFO holds at least one psum vector
- inst  out  47  registered instruction word to core; field map as core.inst (46 CEN_xmem, 45 WEN_xmem, 44:34 A_xmem, 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_wmem, 18 WEN_wmem, 17:7 A_wmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last output
- out_strobe  out  1  one-cycle pulse: the core's SFU output for out_idx is final
- out_idx  out  5  output pixel index 0..len_onij-1, valid with out_strobe
- kij_idx  out  4  current kernel index (debug)

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset values: state=IDLE; inst=IDLE_INST (CEN_*=1, WEN_*=1, all other bits 0); busy=0; done=0; out_strobe=0; out_idx=0; kij_idx=0.
- Output timing: all outputs are registered. inst reflects state/counters one cycle later.
- SRAM timing: reads have 1-cycle latency. Every consumer write strobe (ififo_wr, l0_wr, acc) lags its SRAM read enable by one cycle. A read phase of N words therefore takes N+1 cycles.
- IDLE: start=1 -> WFETCH; kij=0; busy=1 next cycle. start while busy is ignored.
- WFETCH (col+1 cycles), counter c:
  - c<col: CEN_wmem=0, WEN_wmem=1, A_wmem=kij*col+c.
  - c>=1: ififo_wr=1.
- PLOAD (row+col-1 cycles): ififo_rd=1, load=1.
- GAP (gap_cyc cycles): IDLE_INST.
- XFETCH (len_nij+1 cycles):
  - c<len_nij: CEN_xmem=0, WEN_xmem=1, A_xmem=c.
  - c>=1: l0_wr=1.
- EXEC (len_nij+row+col-1 cycles): l0_rd=1, execute=1.
- DRAIN: in each cycle with ofifo_valid=1, assert ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+d, then d++. With ofifo_valid=0, stall and write nothing. Leave when d==len_nij.
- DRAIN exit: kij<len_kij-1 -> kij++, WFETCH; else -> ACC_CLR with o=0.
- ACC_CLR (1 cycle): IDLE_INST. The core clears its SFU accumulator when it sees acc=0 for one cycle.
- ACC_RD (len_kij+1 cycles), counter j:
  - j<len_kij: CEN_pmem=0, WEN_pmem=1, A_pmem=j*len_nij+nij.
  - nij = (oy+kiy)*ni_dim + (ox+kjx), where oy=o/oni_dim, ox=o%oni_dim, kiy=j/ki_dim, kjx=j%ki_dim.
  - j>=1: acc=1.
  - Divide/mod by compile-time constants, or by nested counters (preferred).
- ACC_OUT (1 cycle): acc=0; out_strobe=1, out_idx=o.
- ACC_OUT exit: o<len_onij-1 -> o++, ACC_CLR; else -> FIN.
- FIN: done=1 for one cycle, busy=0; return to IDLE.
- Address widths: all addresses are 11 bits, zero-extended. Max pmem address (len_kij*len_nij-1=323) must fit; parameter sets exceeding 2047 are illegal (elaboration-time check).
- Reset mid-operation: asserting reset returns immediately to IDLE with reset values. No partial-state retention. The core must also be reset by the host.

Decomposition:
- Package conv_seq_pkg:
  - inst bit-position localparams.
  - IDLE_INST constant.
  - state enum: IDLE, WFETCH, PLOAD, GAP, XFETCH, EXEC, DRAIN, ACC_CLR, ACC_RD, ACC_OUT, FIN.
- Sub-module psum_addr_gen:
  - nested oy/ox/kiy/kjx counters.
  - Produces the A_pmem sequence for ACC_RD with step/clear inputs.

Test Plan:
- Reset: assert reset mid-EXEC -> next cycle inst=IDLE_INST (bits 46,45,32,31,19,18 set, rest 0), busy=0. start then reruns from kij=0.
- Single-kij phase timing, ofifo_valid tied 1:
  - WFETCH: A_wmem=0..7 with CEN_wmem=0 for 8 cycles; ififo_wr high cycles 2..9.
  - PLOAD: load high for 15 cycles.
  - XFETCH: l0_wr high for 36 cycles.
  - EXEC: 51 cycles.
- Drain stall: ofifo_valid toggled 1,0,0,1... during kij=2 -> exactly 36 pmem writes at A_pmem 72..107, in order, none during valid=0.
- Accumulation addressing: o=5, j=4 -> A_pmem=4*36+14=158. o=15, j=8 -> A_pmem=8*36+35=323.
- Strobes: out_strobe pulses 16 times with out_idx 0..15; acc high exactly 9 cycles per output; done one pulse after out_idx=15.
- Busy guard: start pulsed during DRAIN -> ignored; run completes once with one done pulse.
